// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port mem arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational 2-way winner select; MEM_ARB_RR_EN selects round-robin vs fixed priority
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_rr_last,
    output logic o_grant,
    output logic o_rr_en
);

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    always_comb begin
        o_grant = PORT_A;
        if (i_req_a && i_req_b)
            o_grant = (i_rr_last == PORT_A) ? PORT_B : PORT_A;
        else if (i_req_b)
            o_grant = PORT_B;
    end
    assign o_rr_en = 1'b1;
`else
    logic w_unused_rr_last;

    assign w_unused_rr_last = i_rr_last;
    assign o_grant          = (i_req_a || !i_req_b) ? PORT_A : PORT_B;
    assign o_rr_en          = 1'b0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises port A (fetch) and port B (load/store) onto the single-port mem
// Tie policy comes from mem_arb_pick (MEM_ARB_RR_EN).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_to_mem,
    input  logic [DATA_W-1:0] mem_from_mem,
    output logic              busy
);

    state_t              r_state;
    logic                r_grant;
    logic                r_we;
    logic                r_rr_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_a_rdata;
    logic [DATA_W-1:0]   r_b_rdata;

    logic                w_grant;
    logic                w_rr_en;
    logic                w_any_req;

    assign w_any_req = a_req | b_req;

    mem_arb_pick u_pick (
        .i_req_a   (a_req),
        .i_req_b   (b_req),
        .i_rr_last (r_rr_last),
        .o_grant   (w_grant),
        .o_rr_en   (w_rr_en)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= PORT_A;
            r_we      <= 1'b0;
            r_rr_last <= PORT_B;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant;
                        r_we    <= (w_grant == PORT_A) ? a_we    : b_we;
                        r_addr  <= (w_grant == PORT_A) ? a_addr  : b_addr;
                        r_wdata <= (w_grant == PORT_A) ? a_wdata : b_wdata;
                        // In fixed-priority builds rr_last stays at its reset value.
                        if (w_rr_en)
                            r_rr_last <= w_grant;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) begin
                        if (r_grant == PORT_A)
                            r_a_rdata <= mem_from_mem;
                        else
                            r_b_rdata <= mem_from_mem;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded from state so an async reset drops mem_write without waiting for an edge.
    assign mem_write   = (r_state == ST_ACCESS) && r_we;
    assign mem_address = r_addr;
    assign mem_to_mem  = r_wdata;
    assign a_ack       = (r_state == ST_RESP) && (r_grant == PORT_A);
    assign b_ack       = (r_state == ST_RESP) && (r_grant == PORT_B);
    assign a_rdata     = r_a_rdata;
    assign b_rdata     = r_b_rdata;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural mem
module tb_mem_arbiter;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ack, b_ack, mem_write, busy;
    logic [7:0] a_rdata, b_rdata, mem_address, mem_to_mem, mem_from_mem;

    logic [7:0] mem [256];
    logic [7:0] model_mem [256];
    logic [7:0] exp_a, exp_b;
    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;

    mem_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_ack        (a_ack),
        .a_rdata      (a_rdata),
        .b_req        (b_req),
        .b_we         (b_we),
        .b_addr       (b_addr),
        .b_wdata      (b_wdata),
        .b_ack        (b_ack),
        .b_rdata      (b_rdata),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_to_mem   (mem_to_mem),
        .mem_from_mem (mem_from_mem),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (mem_write) mem[mem_address] <= mem_to_mem;
    assign mem_from_mem = mem[mem_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack pops the oldest expectation.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && (a_ack || b_ack)) begin
            exp_t e;
            chk("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ack_port", {31'd0, b_ack}, {31'd0, e.port});
                chk("ack_rdata", {24'd0, (b_ack ? b_rdata : a_rdata)}, {24'd0, e.data});
            end
        end
    end

    task automatic expect_op(input logic port, input logic we, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.port = port;
        if (we) begin
            model_mem[addr] = data;
        end else begin
            if (port) exp_b = model_mem[addr];
            else      exp_a = model_mem[addr];
        end
        e.data = port ? exp_b : exp_a;
        q.push_back(e);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(a_ack || b_ack) && n < 20);
        if (!(a_ack || b_ack)) chk("ack_timeout", 32'd1, 32'd0);
    endtask

    task automatic single(input logic port, input logic we, input logic [7:0] addr, input logic [7:0] data);
        int n;
        logic mw1, mw2, mw3;
        expect_op(port, we, addr, data);
        if (port) begin b_we = we; b_addr = addr; b_wdata = data; b_req = 1'b1; end
        else      begin a_we = we; a_addr = addr; a_wdata = data; a_req = 1'b1; end
        n = 0; mw1 = 1'b0; mw2 = 1'b0; mw3 = 1'b0;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) mw1 = mem_write;
            if (n == 2) mw2 = mem_write;
            if (n == 3) mw3 = mem_write;
        end while (!(a_ack || b_ack) && n < 20);
        chk("latency", n, 32'd3);
        chk("mem_write_idle", {31'd0, mw1}, 32'd0);
        chk("mem_write_access", {31'd0, mw2}, {31'd0, we});
        chk("mem_write_resp", {31'd0, mw3}, 32'd0);
        @(posedge clock); #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] tmp;
        for (int i = 0; i < 256; i++) begin
            tmp = i[7:0] ^ 8'h3C;
            mem[i] = tmp;
            model_mem[i] = tmp;
        end
        exp_a = 8'h00; exp_b = 8'h00;
        reset_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clock);
        chk("rst_outputs", {a_ack, b_ack, mem_write, busy, a_rdata, b_rdata, mem_address}, 32'd0);
        chk("rst_to_mem", {24'd0, mem_to_mem}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // A write aborted by reset while in ACCESS.
        @(posedge clock); #1;
        a_we = 1'b1; a_addr = 8'h80; a_wdata = 8'h77; a_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("abort_mem_write_pre", {31'd0, mem_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort_outputs", {a_ack, b_ack, busy, a_rdata, b_rdata, mem_address}, 32'd0);
        a_req = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        single(1'b0, 1'b0, 8'h80, 8'h00);
        chk("abort_old_data", {24'd0, a_rdata}, 32'h000000BC);

        // Single write then read on A.
        single(1'b0, 1'b1, 8'h80, 8'h5A);
        chk("write_keeps_rdata", {24'd0, a_rdata}, 32'h000000BC);
        single(1'b0, 1'b0, 8'h80, 8'h00);
        chk("read_back_5a", {24'd0, a_rdata}, 32'h0000005A);

        // Back-to-back B writes then reads.
        for (int i = 0; i < 16; i++) single(1'b1, 1'b1, 8'h80 + i[7:0], i[7:0]);
        for (int i = 0; i < 16; i++) single(1'b1, 1'b0, 8'h80 + i[7:0], 8'h00);
        chk("b_last_read", {24'd0, b_rdata}, 32'h0000000F);
        chk("a_rdata_unchanged", {24'd0, a_rdata}, 32'h0000005A);

        // B request rising during A's ACCESS waits for the next IDLE.
        expect_op(1'b0, 1'b0, 8'h83, 8'h00);
        expect_op(1'b1, 1'b0, 8'h84, 8'h00);
        a_we = 1'b0; a_addr = 8'h83; a_req = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("busy_access", {31'd0, busy}, 32'd1);
        #1;
        b_we = 1'b0; b_addr = 8'h84; b_req = 1'b1;
        wait_ack(n);
        chk("busy_a_ack", {30'd0, a_ack, b_ack}, 32'd2);
        @(posedge clock); #1;
        a_req = 1'b0;
        wait_ack(n);
        chk("busy_b_spacing", n, 32'd3);
        chk("busy_b_ack", {30'd0, a_ack, b_ack}, 32'd1);
        @(posedge clock); #1;
        b_req = 1'b0;

        // Tie: A reads 0x81 (0x01), B reads 0x82 (0x02), both held.
`ifdef MEM_ARB_RR_EN
        expect_op(1'b0, 1'b0, 8'h81, 8'h00);
        expect_op(1'b1, 1'b0, 8'h82, 8'h00);
        expect_op(1'b0, 1'b0, 8'h81, 8'h00);
        expect_op(1'b1, 1'b0, 8'h82, 8'h00);
`else
        expect_op(1'b0, 1'b0, 8'h81, 8'h00);
        expect_op(1'b0, 1'b0, 8'h81, 8'h00);
        expect_op(1'b0, 1'b0, 8'h81, 8'h00);
        expect_op(1'b1, 1'b0, 8'h82, 8'h00);
`endif
        a_we = 1'b0; a_addr = 8'h81; a_req = 1'b1;
        b_we = 1'b0; b_addr = 8'h82; b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            chk("tie_spacing", n, 32'd3);
`ifndef MEM_ARB_RR_EN
            if (k == 2) begin
                @(posedge clock); #1;
                a_req = 1'b0;
            end
`endif
        end
        @(posedge clock); #1;
        a_req = 1'b0;
        b_req = 1'b0;
        chk("tie_a_rdata", {24'd0, a_rdata}, 32'h00000001);
        chk("tie_b_rdata", {24'd0, b_rdata}, 32'h00000002);

        repeat (6) @(negedge clock);
        chk("queue_drained", q.size(), 32'd0);
        chk("idle_at_end", {31'd0, busy}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
